ex_operand_reg: RTL
===================

Name: ex_operand_reg

Overview:
Single-entry pipeline register directly upstream of the combinational ALU. It captures a decoded operation (rs/rt register values, immediate, 3-bit ALUOp, destination register) with a valid/ready handshake. It resolves data hazards by forwarding from the MEM and WB stages, then presents A, B and ALUOp to the ALU from registers.

Parameters:
WIDTH, 32, datapath width of operands and forwarded data
REG_AW, 5, register-index width (32 architectural registers, $0 hardwired zero)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
flush  in  1  synchronous kill of held and incoming op
in_valid  in  1  upstream op valid
in_ready  out  1  stage can accept op this cycle
in_rs  in  REG_AW  source register index for A
in_rt  in  REG_AW  source register index for B
in_rs_data  in  WIDTH  register-file value of rs
in_rt_data  in  WIDTH  register-file value of rt
in_imm  in  WIDTH  extended immediate
in_use_imm  in  1  B takes in_imm instead of rt value
in_aluop  in  3  ALU operation code
in_rd  in  REG_AW  destination register index
fwd_mem_en  in  1  MEM stage will write a register
fwd_mem_rd  in  REG_AW  MEM destination index
fwd_mem_data  in  WIDTH  MEM result
fwd_wb_en  in  1  WB stage writing a register
fwd_wb_rd  in  REG_AW  WB destination index
fwd_wb_data  in  WIDTH  WB result
out_valid  out  1  A/B/ALUOp valid for ALU
out_ready  in  1  downstream consumes op
A  out  WIDTH  ALU operand A
B  out  WIDTH  ALU operand B
ALUOp  out  3  ALU operation code
out_rd  out  REG_AW  destination index passed along

Behaviour:
- Reset (reset==0, async): out_valid=0, A=0, B=0, ALUOp=3'b000, out_rd=0, stored rs/rt/use_imm=0. All outputs are registered; none depends combinationally on in_* except in_ready.
- in_ready = !out_valid | out_ready (combinational; no skid buffer). Capture when in_valid & in_ready & !flush. Latency 1 cycle: op accepted at edge N is valid on outputs after edge N.
- Forward mux, per source index s with raw value v: if s==0 then 0; else if fwd_mem_en & fwd_mem_rd==s then fwd_mem_data; else if fwd_wb_en & fwd_wb_rd==s then fwd_wb_data; else v. MEM has priority over WB. $0 never forwarded, even if a stage claims rd=0.
- Capture: A <= fwd(in_rs, in_rs_data). B <= in_use_imm ? in_imm : fwd(in_rt, in_rt_data). Also latch ALUOp, out_rd, rs, rt, use_imm.
- Hold (out_valid & !out_ready & !flush): ALUOp and out_rd are stable. A is refreshed each cycle with fwd(stored_rs, A). B is refreshed with fwd(stored_rt, B) only when use_imm==0. A stalled op therefore sees results produced during the stall.
- Pass-through (out_valid & out_ready & in_valid): new op is captured the same edge; out_valid stays 1. If out_ready is high with no in_valid, out_valid drops to 0 and data registers keep their last value.
- flush: highest priority. out_valid <= 0 next edge and any same-cycle input is discarded. in_ready still follows the formula, so upstream sees its op consumed (killed).
- ALUOp passes unmodified. Codes 3'b110/3'b111 are not checked here; the ALU treats them as arithmetic right shift.
- Reset mid-operation: held op is lost and out_valid=0 immediately (async).

Decomposition:
- Shared package: ALUOp constants ADD=000, SUB=001, AND=010, OR=011, SRL=100, SRA=101; WIDTH/REG_AW defaults; ZERO_REG=0.
- One sub-module, fwd_sel: combinational forward mux (index, raw value, MEM/WB ports -> value). It is instantiated twice at the input side and twice on the hold-refresh path, or shared via a mux on the index.

Test Plan:
- Reset low mid-stream with out_valid=1 -> out_valid, A, B, ALUOp, out_rd read 0 without a clock edge. Release, then idle -> in_ready=1.
- in_rs=3 (data 0x11), in_rt=4 (data 0x22), ALUOp=001, no forwards, out_ready=1 -> next cycle A=0x11, B=0x22, ALUOp=001, out_valid=1.
- in_rs=5 with fwd_mem(5,0xAAAA) and fwd_wb(5,0xBBBB) -> A=0xAAAA. in_rt=0 with fwd_mem(0,0xFFFF) -> B=0.
- in_use_imm=1, in_imm=0x0000_8000, fwd_mem(rt,0x1234) -> B=0x0000_8000.
- Op held with out_ready=0, rs=7, A=0x1; two cycles later fwd_wb(7,0x77) -> A=0x77 next edge; in_ready=0 throughout; ALUOp unchanged.
- flush=1 together with in_valid=1 while holding -> out_valid=0 next cycle, incoming op not presented; next op captured normally.

Source files
------------

// File: rtl/ex_operand_reg_pkg.sv
// Shared definitions for the EX operand register: ALU operation codes,
// default widths and the stage's per-cycle update actions.
package ex_operand_reg_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_REG_AW = 5;

  // Register $0 always reads zero and must never receive forwarded data.
  localparam int ZERO_REG = 0;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SRA = 3'b101;

  // What the stage does to its registers at the next clock edge.
  typedef enum logic [2:0] {
    ACT_IDLE,     // nothing held, nothing accepted
    ACT_CAPTURE,  // load a new op (from empty or as pass-through)
    ACT_HOLD,     // stalled: keep op, refresh operands from forwards
    ACT_DRAIN,    // op consumed, no successor: drop valid, keep data
    ACT_FLUSH     // kill held and incoming op
  } stage_act_e;

endpackage

// File: rtl/ex_operand_reg_if.sv
// Handshake, operand and forwarding bundle between decode, the EX operand
// register and the ALU.
interface ex_operand_reg_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);

  logic              flush;

  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] in_rs;
  logic [REG_AW-1:0] in_rt;
  logic [WIDTH-1:0]  in_rs_data;
  logic [WIDTH-1:0]  in_rt_data;
  logic [WIDTH-1:0]  in_imm;
  logic              in_use_imm;
  logic [2:0]        in_aluop;
  logic [REG_AW-1:0] in_rd;

  logic              fwd_mem_en;
  logic [REG_AW-1:0] fwd_mem_rd;
  logic [WIDTH-1:0]  fwd_mem_data;
  logic              fwd_wb_en;
  logic [REG_AW-1:0] fwd_wb_rd;
  logic [WIDTH-1:0]  fwd_wb_data;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic [2:0]        ALUOp;
  logic [REG_AW-1:0] out_rd;

  // Pipeline side that feeds the stage (decode, MEM/WB, ALU ready).
  modport master (
    output flush,
    output in_valid, in_rs, in_rt, in_rs_data, in_rt_data,
    output in_imm, in_use_imm, in_aluop, in_rd,
    output fwd_mem_en, fwd_mem_rd, fwd_mem_data,
    output fwd_wb_en, fwd_wb_rd, fwd_wb_data,
    output out_ready,
    input  in_ready, out_valid, A, B, ALUOp, out_rd
  );

  // The operand register itself.
  modport slave (
    input  flush,
    input  in_valid, in_rs, in_rt, in_rs_data, in_rt_data,
    input  in_imm, in_use_imm, in_aluop, in_rd,
    input  fwd_mem_en, fwd_mem_rd, fwd_mem_data,
    input  fwd_wb_en, fwd_wb_rd, fwd_wb_data,
    input  out_ready,
    output in_ready, out_valid, A, B, ALUOp, out_rd
  );

endinterface

// File: rtl/ex_operand_reg_fwd_sel.sv
// Forwarding mux for one source operand: $0 reads zero, MEM result beats
// WB result, otherwise the raw value passes through.
module ex_operand_reg_fwd_sel
  import ex_operand_reg_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] idx,
  input  logic [WIDTH-1:0]  raw,
  input  logic              mem_en,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [WIDTH-1:0]  mem_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [WIDTH-1:0]  value
);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    value = raw;
    if (idx == REG_AW'(ZERO_REG)) begin
      value = '0;
    end else if (mem_en && (mem_rd == idx)) begin
      value = mem_data;
    end else if (wb_en && (wb_rd == idx)) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/ex_operand_reg.sv
// Single-entry operand register in front of the ALU. Accepts an op with a
// valid/ready handshake, forwards MEM/WB results, and keeps a stalled op's
// operands fresh while it waits for the ALU.
module ex_operand_reg
  import ex_operand_reg_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic          clk,
  input  logic          reset,
  ex_operand_reg_if.slave bus
);

  logic              valid_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [2:0]        aluop_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic              use_imm_q;

  logic [WIDTH-1:0]  in_a_fwd;
  logic [WIDTH-1:0]  in_b_fwd;
  logic [WIDTH-1:0]  hold_a_fwd;
  logic [WIDTH-1:0]  hold_b_fwd;

  logic              in_ready;
  stage_act_e        act;

  // Incoming operands.
  ex_operand_reg_fwd_sel #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_in_a (
    .idx      (bus.in_rs),
    .raw      (bus.in_rs_data),
    .mem_en   (bus.fwd_mem_en),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_en    (bus.fwd_wb_en),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .value    (in_a_fwd)
  );

  ex_operand_reg_fwd_sel #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_in_b (
    .idx      (bus.in_rt),
    .raw      (bus.in_rt_data),
    .mem_en   (bus.fwd_mem_en),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_en    (bus.fwd_wb_en),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .value    (in_b_fwd)
  );

  // Held operands: a stalled op picks up results that retire during the stall.
  ex_operand_reg_fwd_sel #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_hold_a (
    .idx      (rs_q),
    .raw      (a_q),
    .mem_en   (bus.fwd_mem_en),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_en    (bus.fwd_wb_en),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .value    (hold_a_fwd)
  );

  ex_operand_reg_fwd_sel #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_hold_b (
    .idx      (rt_q),
    .raw      (b_q),
    .mem_en   (bus.fwd_mem_en),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_en    (bus.fwd_wb_en),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .value    (hold_b_fwd)
  );

  // No skid buffer: the slot is free when empty or being drained this cycle.
  assign in_ready = !valid_q || bus.out_ready;

  always_comb begin
    act = ACT_IDLE;
    if (bus.flush) begin
      act = ACT_FLUSH;
    end else if (bus.in_valid && in_ready) begin
      act = ACT_CAPTURE;
    end else if (valid_q && !bus.out_ready) begin
      act = ACT_HOLD;
    end else if (valid_q) begin
      act = ACT_DRAIN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      aluop_q   <= ALU_ADD;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      use_imm_q <= 1'b0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          valid_q <= 1'b0;
        end
        ACT_CAPTURE: begin
          valid_q   <= 1'b1;
          a_q       <= in_a_fwd;
          b_q       <= bus.in_use_imm ? bus.in_imm : in_b_fwd;
          aluop_q   <= bus.in_aluop;
          rd_q      <= bus.in_rd;
          rs_q      <= bus.in_rs;
          rt_q      <= bus.in_rt;
          use_imm_q <= bus.in_use_imm;
        end
        ACT_HOLD: begin
          a_q <= hold_a_fwd;
          if (!use_imm_q) begin
            b_q <= hold_b_fwd;
          end
        end
        ACT_DRAIN: begin
          valid_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.ALUOp     = aluop_q;
  assign bus.out_rd    = rd_q;

endmodule
